fetch_controller: RTL and testbench

Sequencer for the instruction-fetch stage of the vector ASIP pipeline. It owns the fetch PC, issues single-outstanding requests to instruction memory and presents fetched instructions to the fetch-decode register. It also handles decode stalls, branch/jump redirects from later stages and memory timeouts. It replaces the free-running PC/adder loop with a handshaked, redirect-aware controller.

---
 rtl/fetch_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_fetch_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller
//   Instruction-fetch sequencer. It owns the fetch PC, keeps at most one
//   request outstanding to instruction memory, and hands each fetched word to
//   the fetch-decode register. It also absorbs decode stalls, takes redirects
//   from later stages and traps on memory timeouts.
//
//   Optional build macro: FETCH_PERF_EN adds the perf_fetched / perf_stall
//   saturating counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               decode cannot take fd_instr this cycle
//   redirect_valid/pc   taken branch/jump target (low two bits ignored)
//   imem_req/addr       one-cycle request strobe and its address
//   imem_rvalid/rdata   memory response
//   pc                  current fetch PC
//   fd_valid/instr/pc   instruction presented to decode
//   fetch_err           sticky timeout error, cleared only by rst
//   perf_fetched/stall  (FETCH_PERF_EN only) delivered count, stall-cycle count
module fetch_controller #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 30,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic               fd_valid,
  output logic [INSTR_W-1:0] fd_instr,
  output logic [ADDR_W-1:0]  fd_pc,
  output logic               fetch_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t               state_r,    state_s;
  logic [ADDR_W-1:0]    pc_r,       pc_s;
  logic                 fd_valid_r, fd_valid_s;
  logic [INSTR_W-1:0]   fd_instr_r, fd_instr_s;
  logic [ADDR_W-1:0]    fd_pc_r,    fd_pc_s;
  logic                 err_r,      err_s;
  logic                 drop_r,     drop_s;
  logic [7:0]           wait_cnt_r, wait_cnt_s;
  logic [ADDR_W-1:0]    redir_pc_s;

  // Redirect targets are always word aligned.
  assign redir_pc_s = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Next-state and next-register computation.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    fd_valid_s = fd_valid_r;
    fd_instr_s = fd_instr_r;
    fd_pc_s    = fd_pc_r;
    err_s      = err_r;
    drop_s     = drop_r;
    wait_cnt_s = wait_cnt_r;

    case (state_r)
      S_BOOT: begin
        state_s = S_REQ;
        if (redirect_valid) begin
          pc_s = redir_pc_s;
        end else begin
          pc_s = pc_r;
        end
      end

      S_REQ: begin
        state_s    = S_WAIT;
        wait_cnt_s = 8'd0;
        // The request already left with the old pc; its answer must be dropped.
        if (redirect_valid) begin
          pc_s       = redir_pc_s;
          fd_valid_s = 1'b0;
          drop_s     = 1'b1;
        end else begin
          drop_s     = drop_r;
        end
      end

      S_WAIT: begin
        wait_cnt_s = wait_cnt_r + 8'd1;
        if (imem_rvalid) begin
          if (redirect_valid || drop_r) begin
            // Stale response: discard and re-request at the (new) pc.
            if (redirect_valid) begin
              pc_s = redir_pc_s;
            end else begin
              pc_s = pc_r;
            end
            drop_s     = 1'b0;
            fd_valid_s = 1'b0;
            state_s    = S_REQ;
          end else begin
            fd_instr_s = imem_rdata;
            fd_pc_s    = pc_r;
            fd_valid_s = 1'b1;
            state_s    = S_HOLD;
          end
        end else if (wait_cnt_r >= 8'(MAX_WAIT - 1)) begin
          state_s    = S_ERR;
          err_s      = 1'b1;
          fd_valid_s = 1'b0;
        end else if (redirect_valid) begin
          // Keep waiting for the outstanding answer, then throw it away.
          pc_s       = redir_pc_s;
          drop_s     = 1'b1;
          fd_valid_s = 1'b0;
        end else begin
          state_s = S_WAIT;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_s       = redir_pc_s;
          fd_valid_s = 1'b0;
          state_s    = S_REQ;
        end else if (!stall) begin
          pc_s       = pc_r + ADDR_W'(3'd4);
          fd_valid_s = 1'b0;
          state_s    = S_REQ;
        end else begin
          state_s = S_HOLD;
        end
      end

      S_ERR: begin
        fd_valid_s = 1'b0;
        state_s    = S_ERR;
      end

      default: begin
        state_s    = S_BOOT;
        fd_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_BOOT;
      pc_r       <= RESET_PC;
      fd_valid_r <= 1'b0;
      fd_instr_r <= {INSTR_W{1'b0}};
      fd_pc_r    <= {ADDR_W{1'b0}};
      err_r      <= 1'b0;
      drop_r     <= 1'b0;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      fd_valid_r <= fd_valid_s;
      fd_instr_r <= fd_instr_s;
      fd_pc_r    <= fd_pc_s;
      err_r      <= err_s;
      drop_r     <= drop_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  assign imem_req  = (state_r == S_REQ);
  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign fd_valid  = fd_valid_r;
  assign fd_instr  = fd_instr_r;
  assign fd_pc     = fd_pc_r;
  assign fetch_err = err_r;

`ifdef FETCH_PERF_EN
  logic        hold_exit_s;
  logic        stall_cyc_s;
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_stall_r;

  assign hold_exit_s = (state_r == S_HOLD) && !redirect_valid && !stall;
  assign stall_cyc_s = (state_r == S_HOLD) && stall;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_r <= 32'd0;
      perf_stall_r   <= 32'd0;
    end else begin
      if (hold_exit_s && (perf_fetched_r != 32'hFFFF_FFFF)) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end
      if (stall_cyc_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_stall   = perf_stall_r;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [29:0] imem_rdata;
  logic [31:0] pc;
  logic        fd_valid;
  logic [29:0] fd_instr;
  logic [31:0] fd_pc;
  logic        fetch_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  fetch_controller dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .fd_valid       (fd_valid),
    .fd_instr       (fd_instr),
    .fd_pc          (fd_pc),
    .fetch_err      (fetch_err)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a REQ cycle: checks the request, answers it one cycle later,
  // and returns at the first HOLD cycle after checking the fd outputs.
  task automatic fetch_to_hold(input logic [31:0] addr, input logic [29:0] data);
    check("req", 64'(imem_req), 64'd1);
    check("req_addr", 64'(imem_addr), 64'(addr));
    tick();
    check("wait_noreq", 64'(imem_req), 64'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 30'd0;
    check("fd_valid", 64'(fd_valid), 64'd1);
    check("fd_pc", 64'(fd_pc), 64'(addr));
    check("fd_instr", 64'(fd_instr), 64'(data));
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 30'd0;
    tick();
    tick();

    // Reset state
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_fd_valid", 64'(fd_valid), 64'd0);
    check("rst_fd_instr", 64'(fd_instr), 64'd0);
    check("rst_fd_pc", 64'(fd_pc), 64'd0);
    check("rst_err", 64'(fetch_err), 64'd0);
`ifdef FETCH_PERF_EN
    check("rst_perf_f", 64'(perf_fetched), 64'd0);
    check("rst_perf_s", 64'(perf_stall), 64'd0);
`endif
    rst = 1'b0;
    tick();                                   // BOOT -> REQ

    // Back-to-back fetches, three cycles apart
    fetch_to_hold(32'h0, 30'h0123_4567);
    tick();
    fetch_to_hold(32'h4, 30'h2AAA_5555);
    tick();
    fetch_to_hold(32'h8, 30'h1555_2AAA);
    tick();

    // Stall five cycles in HOLD
    fetch_to_hold(32'hC, 30'h3FFF_0001);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_fd_valid", 64'(fd_valid), 64'd1);
      check("stall_fd_pc", 64'(fd_pc), 64'hC);
      check("stall_fd_instr", 64'(fd_instr), 64'h3FFF_0001);
      check("stall_noreq", 64'(imem_req), 64'd0);
      check("stall_pc", 64'(pc), 64'hC);
    end
    stall = 1'b0;
    tick();
    check("post_stall_req", 64'(imem_req), 64'd1);
    check("post_stall_addr", 64'(imem_addr), 64'h10);

    // Redirect during WAIT, then the stale response arrives
    tick();                                   // WAIT
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();                                   // still WAIT, drop pending
    redirect_valid = 1'b0;
    check("rw_pc", 64'(pc), 64'h100);
    check("rw_noreq", 64'(imem_req), 64'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 30'h0BAD_0BAD;
    tick();
    imem_rvalid = 1'b0;
    check("rw_fd_valid", 64'(fd_valid), 64'd0);
    check("rw_req", 64'(imem_req), 64'd1);
    check("rw_addr", 64'(imem_addr), 64'h100);

    // Redirect in REQ to the top word, then wrap on increment
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();                                   // WAIT, drop pending
    redirect_valid = 1'b0;
    check("rr_pc", 64'(pc), 64'hFFFF_FFFC);
    imem_rvalid = 1'b1;
    imem_rdata  = 30'h0DEA_D000;
    tick();
    imem_rvalid = 1'b0;
    check("rr_fd_valid", 64'(fd_valid), 64'd0);
    fetch_to_hold(32'hFFFF_FFFC, 30'h1234_5678);
    tick();
    check("wrap_req", 64'(imem_req), 64'd1);
    check("wrap_addr", 64'(imem_addr), 64'h0);

    // Redirect together with stall in HOLD
    fetch_to_hold(32'h0, 30'h0000_00AA);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    check("rs_fd_valid", 64'(fd_valid), 64'd0);
    check("rs_req", 64'(imem_req), 64'd1);
    check("rs_addr", 64'(imem_addr), 64'h200);
`ifdef FETCH_PERF_EN
    check("perf_fetched", 64'(perf_fetched), 64'd5);
    check("perf_stall", 64'(perf_stall), 64'd6);
`endif

    // Timeout: no response, error after 15 WAIT cycles
    tick();                                   // WAIT, count 0
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 14) check("to_err_early", 64'(fetch_err), 64'd0);
      if (i == 15) check("to_err", 64'(fetch_err), 64'd1);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    imem_rvalid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("err_noreq", 64'(imem_req), 64'd0);
      check("err_sticky", 64'(fetch_err), 64'd1);
      check("err_fd_valid", 64'(fd_valid), 64'd0);
      check("err_pc", 64'(pc), 64'h200);
    end
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    rst            = 1'b1;
    tick();
    check("err_rst_clear", 64'(fetch_err), 64'd0);
    check("err_rst_pc", 64'(pc), 64'd0);
    check("err_rst_noreq", 64'(imem_req), 64'd0);
    rst = 1'b0;
    tick();
    check("after_rst_req", 64'(imem_req), 64'd1);
    check("after_rst_addr", 64'(imem_addr), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
